// File: rtl/prio_enc_pkg.sv
// Shared widths, types and constants for the 4-input priority encoder.
// Imported by the interface, the decode sub-module and the top level.
package prio_enc_pkg;

   localparam int N_IN   = 4;
   localparam int CODE_W = 3;

   typedef logic [N_IN:1]     req_t;
   typedef logic [CODE_W-1:0] code_t;

   localparam code_t CODE_NONE = '0;

endpackage : prio_enc_pkg

// File: rtl/priority_encoder_case_if.sv
// Request/code bundle for priority_encoder_case: the request vector in, the registered code out.
// The master drives requests and the slave (the encoder) returns the code.
interface priority_encoder_case_if;
   import prio_enc_pkg::*;

   req_t  x;
   code_t pcode;

   modport master (output x, input  pcode);
   modport slave  (input  x, output pcode);

endinterface : priority_encoder_case_if

// File: rtl/prio_enc_comb.sv
// Combinational priority decode: 1-based index of the highest set request bit, 0 if none.
// Unknown request bits fall to the default arm so they propagate as X in simulation.
module prio_enc_comb
   import prio_enc_pkg::*;
#(
   parameter int N_IN   = 4,
   parameter int CODE_W = 3
) (
   input  logic [N_IN:1]     x,
   output logic [CODE_W-1:0] c
);

   always_comb begin
      c = CODE_NONE;
      casez (x)
         4'b1???: c = CODE_W'(4);
         4'b01??: c = CODE_W'(3);
         4'b001?: c = CODE_W'(2);
         4'b0001: c = CODE_W'(1);
         4'b0000: c = CODE_NONE;
`ifdef SYNTHESIS
         default: c = CODE_NONE;
`else
         default: c = 'x;
`endif
      endcase
   end

endmodule : prio_enc_comb

// File: rtl/priority_encoder_case.sv
// Registered 4-input priority encoder: decode of x is captured on every rising clk edge.
// rst_n is synchronous and active-low; it clears the code to 0.
module priority_encoder_case
   import prio_enc_pkg::*;
#(
   parameter int N_IN   = 4,
   parameter int CODE_W = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   priority_encoder_case_if.slave bus
);

   logic [CODE_W-1:0] pcode_d;
   logic [CODE_W-1:0] pcode_q;

   prio_enc_comb #(
      .N_IN   (N_IN),
      .CODE_W (CODE_W)
   ) u_comb (
      .x (bus.x),
      .c (pcode_d)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) pcode_q <= CODE_NONE;
      else        pcode_q <= pcode_d;
   end

   assign bus.pcode = pcode_q;

endmodule : priority_encoder_case

// File: tb/tb_priority_encoder_case.sv
// Directed bench for priority_encoder_case: reset, sweep, masking, zero, mid-run reset, glitch.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
module tb_priority_encoder_case;
   import prio_enc_pkg::*;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   priority_encoder_case_if bus ();

   priority_encoder_case #(
      .N_IN   (4),
      .CODE_W (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.x = 4'b1111;
      tick();
      checks++;
      if (bus.pcode !== 3'd0) begin
         errors++;
         $display("FAIL reset_edge1: got %0d want 0", bus.pcode);
      end
      tick();
      checks++;
      if (bus.pcode !== 3'd0) begin
         errors++;
         $display("FAIL reset_edge2: got %0d want 0", bus.pcode);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (bus.pcode !== 3'd4) begin
         errors++;
         $display("FAIL reset_release: got %0d want 4", bus.pcode);
      end
   endtask

   task automatic test_sweep();
      int exp_tab [16] = '{0, 1, 2, 2, 3, 3, 3, 3, 4, 4, 4, 4, 4, 4, 4, 4};
      for (int i = 0; i < 16; i++) begin
         bus.x = 4'(i);
         tick();
         checks++;
         if (bus.pcode !== 3'(exp_tab[i])) begin
            errors++;
            $display("FAIL sweep x=%b: got %0d want %0d", 4'(i), bus.pcode, exp_tab[i]);
         end
      end
   endtask

   task automatic test_masking();
      logic [3:0] vec_tab [5] = '{4'b1000, 4'b1111, 4'b0111, 4'b0011, 4'b0001};
      int         exp_tab [5] = '{4, 4, 3, 2, 1};
      for (int i = 0; i < 5; i++) begin
         bus.x = vec_tab[i];
         tick();
         checks++;
         if (bus.pcode !== 3'(exp_tab[i])) begin
            errors++;
            $display("FAIL mask x=%b: got %0d want %0d", vec_tab[i], bus.pcode, exp_tab[i]);
         end
      end
   endtask

   task automatic test_zero();
      bus.x = 4'b1010;
      tick();
      checks++;
      if (bus.pcode !== 3'd4) begin
         errors++;
         $display("FAIL zero_pre: got %0d want 4", bus.pcode);
      end
      bus.x = 4'b0000;
      tick();
      checks++;
      if (bus.pcode !== 3'd0) begin
         errors++;
         $display("FAIL zero: got %0d want 0", bus.pcode);
      end
   endtask

   task automatic test_mid_reset();
      bus.x = 4'b0100;
      tick();
      checks++;
      if (bus.pcode !== 3'd3) begin
         errors++;
         $display("FAIL midrst_pre: got %0d want 3", bus.pcode);
      end
      rst_n = 1'b0;
      tick();
      checks++;
      if (bus.pcode !== 3'd0) begin
         errors++;
         $display("FAIL midrst_assert: got %0d want 0", bus.pcode);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (bus.pcode !== 3'd3) begin
         errors++;
         $display("FAIL midrst_release: got %0d want 3", bus.pcode);
      end
   endtask

   task automatic test_glitch();
      // pcode is 3 from the previous scenario; mid-cycle toggles must not show
      for (int i = 0; i < 6; i++) begin
         bus.x = (i % 2 == 0) ? 4'b0001 : 4'b1000;
         #1;
         checks++;
         if (bus.pcode !== 3'd3) begin
            errors++;
            $display("FAIL glitch_hold step %0d: got %0d want 3", i, bus.pcode);
         end
      end
      bus.x = 4'b0010;
      tick();
      checks++;
      if (bus.pcode !== 3'd2) begin
         errors++;
         $display("FAIL glitch_settle: got %0d want 2", bus.pcode);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      bus.x  = 4'b0000;
      test_reset();
      test_sweep();
      test_masking();
      test_zero();
      test_mid_reset();
      test_glitch();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_priority_encoder_case

// File: doc/priority_encoder_case.md
# priority_encoder_case

Registered 4-input priority encoder. It reports the 1-based index of the highest-numbered asserted request bit on `x[4:1]`, or 0 when no bit is set. It is a small leaf block used wherever a one-hot or multi-hot request vector must be reduced to a binary index. The encode is a case-style priority decode followed by a single output register on the system clock.

## Interface
Parameters:
- `N_IN`, default 4: number of request bits, indexed `N_IN:1`. Only the value 4 is required to be supported.
- `CODE_W`, default 3: output code width, equal to clog2(`N_IN`+1). The code must hold the values 0..`N_IN`.

Ports:
- `clk`, input, 1: system clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset. Synchronous and active-low.
- `x`, input, [4:1]: request vector. Bit 4 has the highest priority and bit 1 the lowest.
- `pcode`, output, [2:0]: registered priority code.

## Operation
- Combinational code `c` is derived from `x` as follows:
  - `x[4]`=1 gives 3'd4.
  - Otherwise, `x[3]`=1 gives 3'd3.
  - Otherwise, `x[2]`=1 gives 3'd2.
  - Otherwise, `x[1]`=1 gives 3'd1.
  - `x`=4'b0000 gives 3'd0.
- Lower-priority bits are don't-care once a higher bit is set. For example, 4'b1111 gives 4, and 4'b0111 gives 3.
- Full truth table over all 16 inputs:
  - 0000 gives 0.
  - 0001 gives 1.
  - 001x gives 2.
  - 01xx gives 3.
  - 1xxx gives 4.
- The decode must be implemented as a complete `case`/`casez` with a default arm, so that no latches are inferred. Codes 5..7 are never produced.
- X or Z on any `x` bit must not be masked. The default arm drives `pcode` to 3'bxxx in simulation only. Synthesis treats that arm as 0.
- `pcode` is loaded with `c` on every rising `clk` edge while `rst_n`=1.
- There is no enable, no handshake, and no further internal state.

## Timing
- Latency: exactly 1 cycle. The value of `x` sampled at edge k appears on `pcode` after edge k and is held until edge k+1.
- `x` must be stable across the setup/hold window of the sampling edge. Changes of `x` between edges have no effect on `pcode`.
- Reset:
  - If `rst_n`=0 at a rising edge, `pcode` becomes 3'd0 after that edge, regardless of `x`.
  - This applies equally to reset asserted in the middle of operation.
  - Deassertion of `rst_n` has no asynchronous effect.
  - At the first edge with `rst_n`=1, `pcode` loads the encode of the sampled `x`.
- The value of `pcode` before the first reset edge is undefined. The bench must not check it.
- Back-to-back input changes on consecutive edges each produce their own code one cycle later. No code is skipped or merged.

## Structure
- Shared package `prio_enc_pkg`:
  - `localparam N_IN = 4`, `CODE_W = 3`.
  - `typedef logic [N_IN:1] req_t`, `typedef logic [CODE_W-1:0] code_t`.
  - `localparam code_t CODE_NONE = '0`.
- One combinational sub-module, `prio_enc_comb` (`x` in, `c` out), containing the `casez` decode.
- The top level `priority_encoder_case` contains the sub-module plus the `rst_n`-gated output register.

## Test plan
- Reset: hold `rst_n`=0 for 2 edges with `x`=4'b1111. Required: `pcode`=0 after the first edge. Then release reset; the next edge gives `pcode`=4.
- Exhaustive sweep: apply `x`=0000..1111 in ascending order, one value per edge. Required sequence one cycle later: 0,1,2,2,3,3,3,3,4,4,4,4,4,4,4,4.
- Priority masking: apply `x`=1000, 1111, 0111, 0011, 0001. Required: 4, 4, 3, 2, 1.
- Zero input: `x`=0000 following `x`=1010 gives 4 then 0. Confirms `pcode` returns to 0 with no stale code.
- Mid-operation reset: while cycling `x`=0100, drive `rst_n`=0 for one edge. Required: `pcode`=0 at that edge, then 3 again on the next edge.
- Intra-cycle glitch: toggle `x` between 0001 and 1000 between clock edges, settling at 0010 before the edge. Required: `pcode`=2, with no intermediate value visible on the output.
